exception_ctrl: RTL

Parametrised exception and interrupt controller for the pipelined MIPS core; it replaces the purely combinational cause decoder.
- Collects the decode-stage causes (syscall, break, undefined), the execute-stage overflow and NUM_IRQ external interrupt lines.
- Latches pending interrupts, resolves priority by instruction age and captures EPC and Cause.
- Sequences flush, handler entry and ERET return with the hazard unit through a request/acknowledge handshake.

---
 rtl/exception_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
// Exception and interrupt controller: collects pipeline causes and interrupt lines,
// captures EPC/Cause, and sequences flush, handler entry and ERET return.
//
// state   | meaning
// IDLE    | normal execution, evaluating causes each cycle
// REQ     | redirect to VECTOR requested, waiting for flush_ack
// HANDLER | handler running (exl=1), waiting for ERET
// RET     | redirect to EPC requested, waiting for flush_ack
module exception_ctrl #(
    parameter int                WIDTH   = 32,
    parameter int                NUM_IRQ = 4,
    parameter int                CAUSE_W = 3,
    parameter logic [WIDTH-1:0]  VECTOR  = 32'h0000_0180
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_ack,
    input  logic                syscall_D,
    input  logic                break_D,
    input  logic                undef_D,
    input  logic                overflow_E,
    input  logic [WIDTH-1:0]    pc_D,
    input  logic [WIDTH-1:0]    pc_E,
    input  logic                eret_D,
    input  logic                flush_ack,
    input  logic                csr_we,
    input  logic                csr_sel,
    input  logic [WIDTH-1:0]    csr_wdata,
    output logic                exc_req,
    output logic [WIDTH-1:0]    exc_pc,
    output logic [WIDTH-1:0]    epc,
    output logic [CAUSE_W-1:0]  int_cause,
    output logic [NUM_IRQ-1:0]  irq_pend,
    output logic                exl,
    output logic                ie,
    output logic [NUM_IRQ-1:0]  irq_mask,
    output logic                dbl_fault
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] HANDLER = 2'd2;
    localparam logic [1:0] RET     = 2'd3;

    localparam logic [CAUSE_W-1:0] C_INT  = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] C_SYS  = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] C_BRK  = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] C_UND  = CAUSE_W'(3);
    localparam logic [CAUSE_W-1:0] C_OVF  = CAUSE_W'(4);

    logic [1:0]          state_q, state_d;
    logic                exc_req_q, exc_req_d;
    logic [WIDTH-1:0]    exc_pc_q, exc_pc_d;
    logic [WIDTH-1:0]    epc_q, epc_d;
    logic [CAUSE_W-1:0]  int_cause_q, int_cause_d;
    logic [NUM_IRQ-1:0]  irq_pend_q, irq_pend_d;
    logic                exl_q, exl_d;
    logic                ie_q, ie_d;
    logic [NUM_IRQ-1:0]  irq_mask_q, irq_mask_d;
    logic                dbl_fault_q, dbl_fault_d;

    logic                int_elig;
    logic                sync_cause;
    logic                unused_wdata;

    assign unused_wdata = ^csr_wdata;

    // Eligibility uses this cycle's pending view so a 1-cycle irq pulse is taken
    // at the edge that samples it; mask/IE use the registered values only.
    assign int_elig   = (|(irq_pend_d & irq_mask_q)) & ie_q & ~exl_q;
    assign sync_cause = syscall_D | break_D | undef_D | overflow_E;

    always_comb begin
        state_d     = state_q;
        exc_req_d   = exc_req_q;
        exc_pc_d    = exc_pc_q;
        epc_d       = epc_q;
        int_cause_d = int_cause_q;
        exl_d       = exl_q;
        dbl_fault_d = dbl_fault_q;
        ie_d        = ie_q;
        irq_mask_d  = irq_mask_q;

        irq_pend_d  = irq | (irq_pend_q & ~irq_ack);

        if (csr_we) begin
            if (csr_sel) ie_d       = csr_wdata[0];
            else         irq_mask_d = csr_wdata[NUM_IRQ-1:0];
        end

        case (state_q)
            IDLE: begin
                if (overflow_E || int_elig || syscall_D || break_D || undef_D) begin
                    state_d   = REQ;
                    exc_req_d = 1'b1;
                    exc_pc_d  = VECTOR;
                    exl_d     = 1'b1;
                    epc_d     = pc_D;
                    if (overflow_E) begin
                        int_cause_d = C_OVF;
                        epc_d       = pc_E;
                    end else if (int_elig) begin
                        int_cause_d = C_INT;
                    end else if (syscall_D) begin
                        int_cause_d = C_SYS;
                    end else if (break_D) begin
                        int_cause_d = C_BRK;
                    end else begin
                        int_cause_d = C_UND;
                    end
                end
            end
            REQ: begin
                if (flush_ack) begin
                    state_d   = HANDLER;
                    exc_req_d = 1'b0;
                end
            end
            HANDLER: begin
                if (sync_cause) dbl_fault_d = 1'b1;
                if (eret_D) begin
                    state_d   = RET;
                    exc_req_d = 1'b1;
                    exc_pc_d  = epc_q;
                end
            end
            RET: begin
                if (flush_ack) begin
                    state_d   = IDLE;
                    exc_req_d = 1'b0;
                    exl_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            exc_req_q   <= 1'b0;
            exc_pc_q    <= '0;
            epc_q       <= '0;
            int_cause_q <= '0;
            irq_pend_q  <= '0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            irq_mask_q  <= '1;
            dbl_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exc_req_q   <= exc_req_d;
            exc_pc_q    <= exc_pc_d;
            epc_q       <= epc_d;
            int_cause_q <= int_cause_d;
            irq_pend_q  <= irq_pend_d;
            exl_q       <= exl_d;
            ie_q        <= ie_d;
            irq_mask_q  <= irq_mask_d;
            dbl_fault_q <= dbl_fault_d;
        end
    end

    assign exc_req   = exc_req_q;
    assign exc_pc    = exc_pc_q;
    assign epc       = epc_q;
    assign int_cause = int_cause_q;
    assign irq_pend  = irq_pend_q;
    assign exl       = exl_q;
    assign ie        = ie_q;
    assign irq_mask  = irq_mask_q;
    assign dbl_fault = dbl_fault_q;

endmodule
